// File: rtl/dot_operand_sequencer.sv
// -----------------------------------------------------------------------------
// dot_operand_sequencer
//
// Operand fetcher and result writer for a combinational dot-product unit.
// For every (i, j) of R = A * B it assembles row i of A into vec_a and
// column j of B into vec_b. It then captures the unit's dot_in result and
// writes it to R[i][j]. A row of A is read once and reused across all
// columns of B.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               begin a full A*B (sampled only while idle)
//   busy, done          run in progress / one-cycle completion pulse
//   rd_req, rd_addr     read request and word address
//   rd_ready            request accepted when rd_req & rd_ready
//   rd_valid, rd_data   read return (at most one request outstanding)
//   vec_a, vec_b        packed operand vectors; element k at [k*DW +: DW]
//   dot_in              dot product of vec_a and vec_b (combinational)
//   wr_en, wr_addr,     write request, address and data; all are held
//   wr_data               stable until accepted
//   wr_ready            write accepted when wr_en & wr_ready
// -----------------------------------------------------------------------------
module dot_operand_sequencer #(
  parameter int N_ROWS     = 4,
  parameter int N_COLS     = 4,
  parameter int M_COLS     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int A_BASE     = 0,
  parameter int B_BASE     = 64,
  parameter int R_BASE     = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_req,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic                         rd_ready,
  input  logic                         rd_valid,
  input  logic [DATA_WIDTH-1:0]        rd_data,
  output logic [N_COLS*DATA_WIDTH-1:0] vec_a,
  output logic [N_COLS*DATA_WIDTH-1:0] vec_b,
  input  logic [DATA_WIDTH-1:0]        dot_in,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         wr_ready
);

  localparam int IW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int JW = (M_COLS > 1) ? $clog2(M_COLS) : 1;
  localparam int KW = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]                   state_q, state_d;
  logic [IW-1:0]                i_q, i_d;
  logic [JW-1:0]                j_q, j_d;
  logic [KW-1:0]                k_q, k_d;
  logic                         pend_q, pend_d;  // a read is accepted, data not yet back
  logic [N_COLS*DATA_WIDTH-1:0] vec_a_q, vec_a_d;
  logic [N_COLS*DATA_WIDTH-1:0] vec_b_q, vec_b_d;
  logic [ADDR_WIDTH-1:0]        wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]        wr_data_q, wr_data_d;

  logic                         loading;
  logic                         k_last;
  logic [ADDR_WIDTH-1:0]        a_addr, b_addr, r_addr;

  assign a_addr = ADDR_WIDTH'(A_BASE) + ADDR_WIDTH'(i_q) * ADDR_WIDTH'(N_COLS) + ADDR_WIDTH'(k_q);
  assign b_addr = ADDR_WIDTH'(B_BASE) + ADDR_WIDTH'(k_q) * ADDR_WIDTH'(M_COLS) + ADDR_WIDTH'(j_q);
  assign r_addr = ADDR_WIDTH'(R_BASE) + ADDR_WIDTH'(i_q) * ADDR_WIDTH'(M_COLS) + ADDR_WIDTH'(j_q);

  assign loading = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign k_last  = (k_q == KW'(N_COLS - 1));

  // The request is raised only when nothing is outstanding. The address is
  // a function of i/j/k, which hold until the data returns, so it remains
  // stable while the request is stalled.
  assign rd_req  = loading && !pend_q;
  assign rd_addr = !rd_req ? '0 : ((state_q == S_LOAD_A) ? a_addr : b_addr);

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done    = (state_q == S_DONE);
  assign wr_en   = (state_q == S_WRITE);
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign vec_a   = vec_a_q;
  assign vec_b   = vec_b_q;

  always_comb begin
    // NOTE: every combinational target gets a default first, so no path leaves it unassigned (no latch).
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    pend_d    = pend_q;
    vec_a_d   = vec_a_q;
    vec_b_d   = vec_b_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end

      S_LOAD_A, S_LOAD_B: begin
        if (!pend_q) begin
          if (rd_ready) pend_d = 1'b1;
        end else if (rd_valid) begin
          // rd_valid counts only while a request is outstanding.
          pend_d = 1'b0;
          if (state_q == S_LOAD_A) vec_a_d[int'(k_q)*DATA_WIDTH +: DATA_WIDTH] = rd_data;
          else                     vec_b_d[int'(k_q)*DATA_WIDTH +: DATA_WIDTH] = rd_data;
          if (k_last) begin
            k_d     = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_CAPTURE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      // Both vectors are complete and hold here, so dot_in is settled.
      S_CAPTURE: begin
        wr_data_d = dot_in;
        wr_addr_d = r_addr;
        state_d   = S_WRITE;
      end

      S_WRITE: begin
        if (wr_ready) begin
          if (j_q != JW'(M_COLS - 1)) begin
            j_d     = j_q + JW'(1);
            state_d = S_LOAD_B;  // vec_a already holds row i
          end else begin
            j_d = '0;
            if (i_q != IW'(N_ROWS - 1)) begin
              i_d     = i_q + IW'(1);
              state_d = S_LOAD_A;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the operand vectors are output registers, not RAM, so they are reset with the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      pend_q    <= 1'b0;
      vec_a_q   <= '0;
      vec_b_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      // NOTE: non-blocking updates let every register sample pre-edge values.
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      pend_q    <= pend_d;
      vec_a_q   <= vec_a_d;
      vec_b_q   <= vec_b_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule
